// File: rtl/mult14x16_pkg.sv
// Shared widths, latency and product type for the 14x16 carry-save multiplier.
// MULT_PIPE_EN selects the two-stage build (LATENCY = 2).
package mult14x16_pkg;

    localparam int unsigned A_W = 14;
    localparam int unsigned B_W = 16;
    localparam int unsigned P_W = A_W + B_W;

`ifdef MULT_PIPE_EN
    localparam int unsigned LATENCY = 2;
`else
    localparam int unsigned LATENCY = 1;
`endif

    typedef logic [P_W-1:0] prod_t;

endpackage

// File: rtl/mult14x16_cs_csa32.sv
// One P_W-wide 3:2 carry-save row: sum = x^y^z, carry = majority(x,y,z) << 1.
module csa32
    import mult14x16_pkg::*;
(
    input  prod_t x,
    input  prod_t y,
    input  prod_t z,
    output prod_t sum,
    output prod_t carry
);

    assign sum   = x ^ y ^ z;
    // Majority MSB falls off the top; the result is only meaningful mod 2^P_W.
    assign carry = ((x & y) | (x & z) | (y & z)) << 1;

endmodule

// File: rtl/mult14x16_cs.sv
// Unsigned 14x16 multiplier, Wallace-style 3:2 tree, carry-save registered output.
// Define MULT_PIPE_EN to register the 5-row midpoint of the tree (latency 2).
module mult14x16_cs
    import mult14x16_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    input  logic [A_W-1:0] A,
    input  logic [B_W-1:0] B,
    output logic           out_valid,
    output logic [P_W-1:0] out1,
    output logic [P_W-1:0] out2
);

    prod_t pp [A_W];

    always_comb begin
        for (int unsigned i = 0; i < A_W; i++) begin
            pp[i] = A[i] ? (prod_t'(B) << i) : '0;
        end
    end

    // Row counts per level: 14 -> 10 -> 7 -> 5 | 4 -> 3 -> 2
    prod_t l1 [10];
    prod_t l2 [7];
    prod_t l3 [5];
    prod_t l3_q [5];
    prod_t l4 [4];
    prod_t l5 [3];
    prod_t sum_d;
    prod_t carry_d;
    logic  stage_valid;

    for (genvar g = 0; g < 4; g++) begin : g_l1
        csa32 u_csa (
            .x(pp[3*g]), .y(pp[3*g+1]), .z(pp[3*g+2]),
            .sum(l1[2*g]), .carry(l1[2*g+1])
        );
    end
    assign l1[8] = pp[12];
    assign l1[9] = pp[13];

    for (genvar g = 0; g < 3; g++) begin : g_l2
        csa32 u_csa (
            .x(l1[3*g]), .y(l1[3*g+1]), .z(l1[3*g+2]),
            .sum(l2[2*g]), .carry(l2[2*g+1])
        );
    end
    assign l2[6] = l1[9];

    for (genvar g = 0; g < 2; g++) begin : g_l3
        csa32 u_csa (
            .x(l2[3*g]), .y(l2[3*g+1]), .z(l2[3*g+2]),
            .sum(l3[2*g]), .carry(l3[2*g+1])
        );
    end
    assign l3[4] = l2[6];

`ifdef MULT_PIPE_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 5; i++) begin
                l3_q[i] <= '0;
            end
            stage_valid <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < 5; i++) begin
                l3_q[i] <= l3[i];
            end
            stage_valid <= in_valid;
        end
    end
`else
    assign l3_q        = l3;
    assign stage_valid = in_valid;
`endif

    csa32 u_csa_l4 (
        .x(l3_q[0]), .y(l3_q[1]), .z(l3_q[2]),
        .sum(l4[0]), .carry(l4[1])
    );
    assign l4[2] = l3_q[3];
    assign l4[3] = l3_q[4];

    csa32 u_csa_l5 (
        .x(l4[0]), .y(l4[1]), .z(l4[2]),
        .sum(l5[0]), .carry(l5[1])
    );
    assign l5[2] = l4[3];

    csa32 u_csa_l6 (
        .x(l5[0]), .y(l5[1]), .z(l5[2]),
        .sum(sum_d), .carry(carry_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out1      <= '0;
            out2      <= '0;
            out_valid <= 1'b0;
        end else begin
            out1      <= sum_d;
            out2      <= carry_d;
            out_valid <= stage_valid;
        end
    end

endmodule

// File: tb/tb_mult14x16_cs.sv
// Directed + random bench for mult14x16_cs; checks (out1+out2) mod 2^30 and out_valid timing.
module tb_mult14x16_cs;
    import mult14x16_pkg::*;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic [A_W-1:0] A;
    logic [B_W-1:0] B;
    logic           out_valid;
    logic [P_W-1:0] out1;
    logic [P_W-1:0] out2;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Expected (valid, sum) per pipeline slot; index LATENCY-1 is what the outputs show.
    logic           md_v [LATENCY];
    logic [P_W-1:0] md_s [LATENCY];

    mult14x16_cs u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A), .B(B),
        .out_valid(out_valid), .out1(out1), .out2(out2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [P_W-1:0] obs, input logic [P_W-1:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input string tag, input logic rst, input logic v,
                        input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                        input logic [P_W-1:0] es);
        logic [P_W-1:0] s;
        rst_n = rst; in_valid = v; A = a; B = b;
        @(posedge clk);
        #1;
        if (!rst) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                md_v[i] = 1'b0;
                md_s[i] = '0;
            end
        end else begin
            for (int i = int'(LATENCY) - 1; i > 0; i--) begin
                md_v[i] = md_v[i-1];
                md_s[i] = md_s[i-1];
            end
            md_v[0] = v;
            md_s[0] = es;
        end
        s = out1 + out2;
        chk({tag, "_sum"}, s, md_s[LATENCY-1]);
        chk({tag, "_valid"}, P_W'(out_valid), P_W'(md_v[LATENCY-1]));
        if (!rst) begin
            chk({tag, "_out1_zero"}, out1, '0);
            chk({tag, "_out2_zero"}, out2, '0);
        end
    endtask

    initial begin
        logic [A_W-1:0] ra;
        logic [B_W-1:0] rb;
        rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0;
        for (int i = 0; i < int'(LATENCY); i++) begin
            md_v[i] = 1'b0;
            md_s[i] = '0;
        end

        for (int i = 0; i < 4; i++) tick("reset", 1'b0, 1'b1, 14'd16383, 16'd65535, 30'd0);

        tick("one",     1'b1, 1'b1, 14'd1,     16'd1,     30'd1);
        tick("a_zero",  1'b1, 1'b1, 14'd0,     16'd12345, 30'd0);
        tick("b_zero",  1'b1, 1'b1, 14'd16383, 16'd0,     30'd0);
        tick("max",     1'b1, 1'b1, 14'd16383, 16'd65535, 30'h3FFEC001);
        tick("typ",     1'b1, 1'b1, 14'd123,   16'd456,   30'd56088);
        tick("pow2",    1'b1, 1'b1, 14'd8192,  16'd32768, 30'd268435456);
        tick("idle",    1'b1, 1'b0, 14'd0,     16'd0,     30'd0);
        tick("drain",   1'b1, 1'b0, 14'd0,     16'd0,     30'd0);

        tick("str0",    1'b1, 1'b1, 14'd3,     16'd5,     30'd15);
        tick("str1",    1'b1, 1'b1, 14'd100,   16'd200,   30'd20000);
        tick("str2",    1'b1, 1'b1, 14'd16383, 16'd1,     30'd16383);

        tick("bub0",    1'b1, 1'b1, 14'd7,     16'd9,     30'd63);
        tick("bub1",    1'b1, 1'b0, 14'd11,    16'd13,    30'd143);
        tick("bub2",    1'b1, 1'b1, 14'd1000,  16'd1000,  30'd1000000);

        tick("mid0",    1'b1, 1'b1, 14'd50,    16'd60,    30'd3000);
        tick("mid1",    1'b1, 1'b1, 14'd70,    16'd80,    30'd5600);
        tick("midrst",  1'b0, 1'b1, 14'd90,    16'd90,    30'd0);
        tick("resume0", 1'b1, 1'b1, 14'd12,    16'd12,    30'd144);
        tick("resume1", 1'b1, 1'b1, 14'd4096,  16'd4096,  30'd16777216);
        tick("resume2", 1'b1, 1'b0, 14'd0,     16'd0,     30'd0);
        tick("resume3", 1'b1, 1'b0, 14'd0,     16'd0,     30'd0);

        for (int n = 0; n < 10000; n++) begin
            ra = A_W'($urandom);
            rb = B_W'($urandom);
            tick("rand", 1'b1, 1'b1, ra, rb, P_W'(P_W'(ra) * P_W'(rb)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
